// File: rtl/fft_rx_pkg.sv
// Shared types, sizing helpers and saturation for the FFT band sink.
// Optional macro BAND_PEAK_EN selects the peak-hold band level instead of the mean.
package fft_rx_pkg;

  typedef enum logic [1:0] {StIdle, StRecv, StDrop, StPublish} rx_state_e;

  // Production configuration of the audio path.
  localparam int unsigned FRAME_LEN_DEF = 8192;
  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned NUM_BANDS_DEF = 4;

  // Bins per band over the non-redundant half of the spectrum.
  function automatic int unsigned calc_bpb(input int unsigned frame_len,
                                           input int unsigned num_bands);
    return frame_len / (2 * num_bands);
  endfunction

  // Peak hold only needs to hold one magnitude; the mean needs sum headroom.
  function automatic int unsigned calc_acc_w(input int unsigned data_w,
                                             input int unsigned log_bpb);
`ifdef BAND_PEAK_EN
    return data_w + 1 + 0 * log_bpb;
`else
    return data_w + 1 + log_bpb;
`endif
  endfunction

  localparam int unsigned BPB    = calc_bpb(FRAME_LEN_DEF, NUM_BANDS_DEF);
  localparam int unsigned BIN_W  = $clog2(FRAME_LEN_DEF);
  localparam int unsigned ACC_W  = calc_acc_w(DATA_W_DEF, $clog2(BPB));
  localparam int unsigned ADDR_W = $clog2(NUM_BANDS_DEF);

  // Clamp an unsigned value to the largest value representable in width bits.
  function automatic logic [63:0] saturate(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (64'd1 << width) - 64'd1;
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/fft_band_sink_mag.sv
// cplx_mag_approx: combinational |re| + |im| without wrap on the most negative input.
module cplx_mag_approx #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] re,
  input  logic [DATA_W-1:0] im,
  output logic [DATA_W:0]   mag
);

  logic [DATA_W:0] re_ext, im_ext, re_abs, im_abs;

  // Sign-extend first so that -2^(DATA_W-1) negates to +2^(DATA_W-1).
  always_comb begin
    re_ext = {re[DATA_W-1], re};
    im_ext = {im[DATA_W-1], im};
    re_abs = re_ext[DATA_W] ? (~re_ext + 1'b1) : re_ext;
    im_abs = im_ext[DATA_W] ? (~im_ext + 1'b1) : im_ext;
    mag    = re_abs + im_abs;
  end

endmodule

// File: rtl/fft_band_sink.sv
// FFT bin stream sink: framing check, per-band magnitude reduction, VGA publish.
// Optional macro BAND_PEAK_EN: band level is the peak magnitude instead of the mean.
module fft_band_sink
  import fft_rx_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned NUM_BANDS = NUM_BANDS_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sink_valid,
  output logic                         sink_ready,
  input  logic                         sink_sop,
  input  logic                         sink_eop,
  input  logic [DATA_W-1:0]            sink_real,
  input  logic [DATA_W-1:0]            sink_imag,
  output logic [DATA_W-1:0]            vga_dat,
  output logic [$clog2(NUM_BANDS)-1:0] vga_addr,
  output logic                         vga_dowrite,
  output logic                         vga_select,
  output logic                         frame_err
);

  localparam int unsigned BinW   = $clog2(FRAME_LEN);
  localparam int unsigned AddrW  = $clog2(NUM_BANDS);
  localparam int unsigned LogBpb = $clog2(calc_bpb(FRAME_LEN, NUM_BANDS));
  localparam int unsigned AccW   = calc_acc_w(DATA_W, LogBpb);
  localparam logic [BinW-1:0]  LastBin  = BinW'(FRAME_LEN - 1);
  localparam logic [AddrW-1:0] LastBand = AddrW'(NUM_BANDS - 1);

  rx_state_e        state_q, state_d;
  logic [BinW-1:0]  bin_q, bin_d;
  logic [AddrW-1:0] pub_q, pub_d;
  logic             err_q, err_d;
  logic [AccW-1:0]  acc_q [NUM_BANDS];
  logic [AccW-1:0]  acc_d [NUM_BANDS];

  logic [DATA_W:0]  mag;
  logic             beat, restart, do_acc, in_range;
  logic [AddrW-1:0] band;

  cplx_mag_approx #(
    .DATA_W(DATA_W)
  ) u_mag (
    .re (sink_real),
    .im (sink_imag),
    .mag(mag)
  );

  assign sink_ready = (state_q != StPublish);
  assign beat       = sink_valid && sink_ready;

  // Framing FSM next state plus band accumulation for the accepted beat.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    pub_d   = pub_q;
    err_d   = 1'b0;
    acc_d   = acc_q;
    restart = 1'b0;
    do_acc  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (beat && sink_sop) begin
          if (sink_eop) begin
            err_d = 1'b1;
          end else begin
            restart = 1'b1;
            state_d = StRecv;
          end
        end
      end
      StRecv: begin
        if (beat) begin
          if (sink_sop && sink_eop) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (sink_sop) begin
            err_d   = 1'b1;
            restart = 1'b1;
          end else if (sink_eop) begin
            if (bin_q == LastBin) begin
              state_d = StPublish;
              pub_d   = '0;
            end else begin
              err_d   = 1'b1;
              state_d = StIdle;
            end
            bin_d = '0;
          end else if (bin_q == LastBin) begin
            err_d   = 1'b1;
            state_d = StDrop;
            bin_d   = '0;
          end else begin
            do_acc = 1'b1;
            bin_d  = bin_q + 1'b1;
          end
        end
      end
      StDrop: begin
        if (beat) begin
          if (sink_sop && sink_eop) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (sink_sop) begin
            err_d   = 1'b1;
            restart = 1'b1;
            state_d = StRecv;
          end else if (sink_eop) begin
            state_d = StIdle;
          end
        end
      end
      StPublish: begin
        pub_d = pub_q + 1'b1;
        if (pub_q == LastBand) begin
          state_d = StIdle;
          pub_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // A restart beat is bin 0 of a fresh frame.
    if (restart) begin
      for (int b = 0; b < NUM_BANDS; b++) acc_d[b] = '0;
      do_acc = 1'b1;
      bin_d  = BinW'(1);
    end

    band     = restart ? '0 : bin_q[BinW-2 -: AddrW];
    in_range = restart || !bin_q[BinW-1];
    if (do_acc && in_range) begin
`ifdef BAND_PEAK_EN
      if (AccW'(mag) > acc_d[band]) acc_d[band] = AccW'(mag);
`else
      acc_d[band] = acc_d[band] + AccW'(mag);
`endif
    end
  end

  // State, counters and accumulators; reset aborts any frame or publish at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      pub_q   <= '0;
      err_q   <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) acc_q[b] <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      pub_q   <= pub_d;
      err_q   <= err_d;
      for (int b = 0; b < NUM_BANDS; b++) acc_q[b] <= acc_d[b];
    end
  end

  // VGA port driven from registered publish state only.
  always_comb begin
    vga_dowrite = (state_q == StPublish);
    vga_select  = vga_dowrite;
    vga_addr    = pub_q;
    frame_err   = err_q;
    vga_dat     = '0;
    if (vga_dowrite) begin
`ifdef BAND_PEAK_EN
      vga_dat = DATA_W'(saturate(64'(acc_q[pub_q]), DATA_W));
`else
      vga_dat = DATA_W'(saturate(64'(acc_q[pub_q] >> LogBpb), DATA_W));
`endif
    end
  end

endmodule
